// File: rtl/calendar_date_counter_pkg.sv
// Shared calendar constants and date arithmetic for the century clock.
package calendar_pkg;

  localparam logic [3:0] JAN = 4'd1;
  localparam logic [3:0] FEB = 4'd2;
  localparam logic [3:0] MAR = 4'd3;
  localparam logic [3:0] APR = 4'd4;
  localparam logic [3:0] MAY = 4'd5;
  localparam logic [3:0] JUN = 4'd6;
  localparam logic [3:0] JUL = 4'd7;
  localparam logic [3:0] AUG = 4'd8;
  localparam logic [3:0] SEP = 4'd9;
  localparam logic [3:0] OCT = 4'd10;
  localparam logic [3:0] NOV = 4'd11;
  localparam logic [3:0] DEC = 4'd12;

  typedef enum logic [1:0] {
    FLD_DAY   = 2'd0,
    FLD_MONTH = 2'd1,
    FLD_YEAR  = 2'd2,
    FLD_NONE  = 2'd3
  } field_e;

  function automatic logic is_leap(input int unsigned full_year, input bit gregorian);
    logic div4;
    logic century_ok;
    div4       = (full_year % 4) == 0;
    century_ok = ((full_year % 100) != 0) || ((full_year % 400) == 0);
    return div4 && (gregorian ? century_ok : 1'b1);
  endfunction

  function automatic logic [4:0] days_in_month(input logic [3:0] month, input logic leap);
    logic [4:0] len;
    case (month)
      JAN, MAR, MAY, JUL, AUG, OCT, DEC: len = 5'd31;
      FEB:                               len = leap ? 5'd29 : 5'd28;
      default:                           len = 5'd30;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/calendar_date_counter_month_length.sv
// Combinational length of a month given the leap flag of its year.
module month_length
  import calendar_pkg::*;
(
  input  logic [3:0] month_i,
  input  logic       leap_i,
  output logic [4:0] day_max_o
);

  always_comb begin
    day_max_o = days_in_month(month_i, leap_i);
  end

endmodule

// File: rtl/calendar_date_counter.sv
// Day/month/year counter with run-mode advance, per-field setup and
// day clamping so that no cycle ever presents an invalid date.
module calendar_date_counter
  import calendar_pkg::*;
#(
  parameter int YEAR_W       = 7,
  parameter int YEAR_MAX     = 99,
  parameter int CENTURY_BASE = 2000,
  parameter int GREGORIAN    = 1,
  parameter int RST_DAY      = 1,
  parameter int RST_MONTH    = 1,
  parameter int RST_YEAR     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_mode,
  input  logic              day_tick,
  input  logic [1:0]        sel_field,
  input  logic              adj_pulse,
  input  logic              adj_up,
  output logic [4:0]        day,
  output logic [3:0]        month,
  output logic [YEAR_W-1:0] year,
  output logic              leap,
  output logic [4:0]        day_max,
  output logic              century_carry
);

  if (YEAR_W < 1 || YEAR_W > 30 || YEAR_MAX < 0 || YEAR_MAX >= (1 << YEAR_W)) begin : g_bad_year
    $error("calendar_date_counter: YEAR_MAX does not fit in YEAR_W");
  end
  if (RST_DAY < 1 || RST_DAY > 28 || RST_MONTH < 1 || RST_MONTH > 12 ||
      RST_YEAR < 0 || RST_YEAR > YEAR_MAX) begin : g_bad_rst
    $error("calendar_date_counter: illegal reset date");
  end

  localparam int unsigned       BASE_U = CENTURY_BASE;
  localparam bit                GREG   = (GREGORIAN != 0);
  localparam logic [YEAR_W-1:0] YMAX   = YEAR_W'(YEAR_MAX);
  localparam logic [YEAR_W-1:0] YONE   = YEAR_W'(1);

  logic [4:0]        day_q, day_d;
  logic [3:0]        month_q, month_d;
  logic [YEAR_W-1:0] year_q, year_d;
  logic              carry_q, carry_d;

  logic   advance, adjust, month_end;
  field_e sel;

  assign leap = is_leap(BASE_U + 32'(year_q), GREG);

  month_length u_month_length (
    .month_i   (month_q),
    .leap_i    (leap),
    .day_max_o (day_max)
  );

  assign advance   = run_mode && day_tick;
  assign adjust    = !run_mode && adj_pulse;
  assign month_end = (day_q == day_max);
  assign sel       = field_e'(sel_field);

  always_comb begin
    year_d  = year_q;
    carry_d = 1'b0;
    if (advance) begin
      if (month_end && month_q == DEC) begin
        if (year_q == YMAX) begin
          year_d  = '0;
          carry_d = 1'b1;
        end else begin
          year_d = year_q + YONE;
        end
      end
    end else if (adjust && sel == FLD_YEAR) begin
      if (adj_up) year_d = (year_q == YMAX) ? '0 : year_q + YONE;
      else        year_d = (year_q == '0) ? YMAX : year_q - YONE;
    end
  end

  always_comb begin
    month_d = month_q;
    if (advance) begin
      if (month_end) month_d = (month_q == DEC) ? JAN : month_q + 4'd1;
    end else if (adjust && sel == FLD_MONTH) begin
      if (adj_up) month_d = (month_q == DEC) ? JAN : month_q + 4'd1;
      else        month_d = (month_q == JAN) ? DEC : month_q - 4'd1;
    end
  end

  // Clamp against the length of the month being entered, not the current one,
  // so a month/year change and its day correction land in the same update.
  always_comb begin
    logic [4:0] new_len;
    day_d = day_q;
    if (advance) begin
      day_d = month_end ? 5'd1 : day_q + 5'd1;
    end else if (adjust && sel == FLD_DAY) begin
      if (adj_up) day_d = (day_q >= day_max) ? 5'd1 : day_q + 5'd1;
      else        day_d = (day_q <= 5'd1) ? day_max : day_q - 5'd1;
    end
    new_len = days_in_month(month_d, is_leap(BASE_U + 32'(year_d), GREG));
    if (day_d > new_len) day_d = new_len;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      day_q   <= 5'(RST_DAY);
      month_q <= 4'(RST_MONTH);
      year_q  <= YEAR_W'(RST_YEAR);
      carry_q <= 1'b0;
    end else begin
      day_q   <= day_d;
      month_q <= month_d;
      year_q  <= year_d;
      carry_q <= carry_d;
    end
  end

  assign day           = day_q;
  assign month         = month_q;
  assign year          = year_q;
  assign century_carry = carry_q;

endmodule

// File: tb/tb_calendar_date_counter.sv
// Directed bench for calendar_date_counter: reset, leap rules, wraps and clamping.
module tb_calendar_date_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       run_mode;
  logic       day_tick;
  logic [1:0] sel_field;
  logic       adj_pulse;
  logic       adj_up;
  logic [4:0] day;
  logic [3:0] month;
  logic [6:0] year;
  logic       leap;
  logic [4:0] day_max;
  logic       century_carry;

  logic [4:0] b_day;
  logic [3:0] b_month;
  logic [6:0] b_year;
  logic       b_leap;
  logic [4:0] b_day_max;
  logic       b_carry;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] S_DAY = 2'd0, S_MON = 2'd1, S_YEAR = 2'd2, S_NONE = 2'd3;

  always #5 clk = ~clk;

  calendar_date_counter #(.YEAR_W(7), .YEAR_MAX(99), .CENTURY_BASE(2000), .GREGORIAN(1),
                          .RST_DAY(1), .RST_MONTH(1), .RST_YEAR(0)) dut (
    .clk(clk), .rst(rst), .run_mode(run_mode), .day_tick(day_tick),
    .sel_field(sel_field), .adj_pulse(adj_pulse), .adj_up(adj_up),
    .day(day), .month(month), .year(year), .leap(leap), .day_max(day_max),
    .century_carry(century_carry)
  );

  calendar_date_counter #(.CENTURY_BASE(2100)) dut2100 (
    .clk(clk), .rst(rst), .run_mode(run_mode), .day_tick(day_tick),
    .sel_field(sel_field), .adj_pulse(adj_pulse), .adj_up(adj_up),
    .day(b_day), .month(b_month), .year(b_year), .leap(b_leap), .day_max(b_day_max),
    .century_carry(b_carry)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_date(input string tag, input int d, input int m, input int y);
    chk({tag, ".day"}, 32'(day), d);
    chk({tag, ".month"}, 32'(month), m);
    chk({tag, ".year"}, 32'(year), y);
    chk({tag, ".carry"}, 32'(century_carry), 0);
  endtask

  task automatic adj(input logic [1:0] sel, input logic up, input int n);
    for (int i = 0; i < n; i++) begin
      sel_field = sel;
      adj_up    = up;
      adj_pulse = 1'b1;
      @(posedge clk);
      #1;
      adj_pulse = 1'b0;
    end
  endtask

  task automatic tick();
    day_tick = 1'b1;
    @(posedge clk);
    #1;
    day_tick = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run_mode = 1'b0; day_tick = 1'b0;
    sel_field = S_NONE; adj_pulse = 1'b0; adj_up = 1'b0;
    @(posedge clk);
    #1;
    chk_date("reset", 1, 1, 0);
    chk("reset.leap", 32'(leap), 1);
    chk("reset.day_max", 32'(day_max), 31);
    chk("base2100.leap", 32'(b_leap), 0);
    chk("base2100.day_max", 32'(b_day_max), 31);
    rst = 1'b0;

    // build 28/02/01
    adj(S_YEAR, 1'b1, 1);
    adj(S_MON, 1'b1, 1);
    adj(S_DAY, 1'b0, 1);
    chk_date("set_280201", 28, 2, 1);
    chk("feb01.day_max", 32'(day_max), 28);
    chk("feb01.leap", 32'(leap), 0);

    run_mode = 1'b1;
    tick();
    chk_date("run_feb01_end", 1, 3, 1);

    // build 28/02/04 then advance into the leap day
    run_mode = 1'b0;
    adj(S_YEAR, 1'b1, 3);
    adj(S_MON, 1'b0, 1);
    adj(S_DAY, 1'b0, 1);
    chk_date("day_down_wrap_feb04", 29, 2, 4);
    adj(S_DAY, 1'b0, 1);
    chk_date("set_280204", 28, 2, 4);
    chk("feb04.day_max", 32'(day_max), 29);
    chk("feb04.leap", 32'(leap), 1);
    chk("base2100.2104.leap", 32'(b_leap), 1);
    run_mode = 1'b1;
    tick();
    chk_date("run_leap_day", 29, 2, 4);
    chk("leap_day.day_max", 32'(day_max), 29);

    run_mode = 1'b0;
    adj(S_YEAR, 1'b1, 1);
    chk_date("clamp_year", 28, 2, 5);

    adj(S_YEAR, 1'b0, 4);
    adj(S_MON, 1'b0, 1);
    adj(S_DAY, 1'b1, 3);
    chk_date("set_310101", 31, 1, 1);
    adj(S_MON, 1'b1, 1);
    chk_date("clamp_month", 28, 2, 1);

    adj(S_MON, 1'b1, 2);
    chk_date("to_april", 28, 4, 1);
    adj(S_DAY, 1'b1, 3);
    chk_date("day_up_wrap_apr", 1, 4, 1);
    adj(S_DAY, 1'b0, 1);
    chk_date("day_down_wrap_apr", 30, 4, 1);

    adj(S_YEAR, 1'b0, 1);
    chk_date("year_down_1", 30, 4, 0);
    adj(S_YEAR, 1'b0, 1);
    chk_date("year_down_wrap", 30, 4, 99);
    chk("y99.leap", 32'(leap), 0);

    tick();
    chk_date("tick_in_setup", 30, 4, 99);
    adj(S_NONE, 1'b1, 1);
    chk_date("sel_none", 30, 4, 99);
    run_mode = 1'b1;
    adj(S_DAY, 1'b1, 1);
    chk_date("adj_in_run", 30, 4, 99);

    run_mode = 1'b0;
    adj(S_MON, 1'b1, 8);
    adj(S_DAY, 1'b1, 1);
    chk_date("set_311299", 31, 12, 99);
    run_mode = 1'b1;
    tick();
    chk("wrap.day", 32'(day), 1);
    chk("wrap.month", 32'(month), 1);
    chk("wrap.year", 32'(year), 0);
    chk("wrap.carry", 32'(century_carry), 1);
    @(posedge clk);
    #1;
    chk("wrap.carry_drop", 32'(century_carry), 0);
    chk("wrap.day_hold", 32'(day), 1);

    tick();
    chk_date("run_0201", 2, 1, 0);

    // async reset between edges with day_tick held high
    day_tick = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk_date("async_rst_now", 1, 1, 0);
    @(posedge clk);
    #1;
    chk_date("async_rst_held", 1, 1, 0);
    day_tick = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_date("after_rst", 1, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
